// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl
//  Purpose  : Instruction-fetch sequencer. Walks IDLE -> T0 -> T1 -> T2
//             (-> T3) -> DONE, issuing bus-source selects and register
//             load/increment strobes, waiting on mem_ready with a timeout.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1   clock, all state updates on rising edge
//    clr        in   1   synchronous active-high reset
//    start      in   1   request to begin a fetch
//    halt       in   1   blocks starting a new fetch (never aborts one)
//    mem_ready  in   1   memory read data valid this cycle
//    ir_in      in  16   current IR contents
//    bus_sel    out  3   bus source: 0 none, 1 AR, 2 PC, 3 IR, 7 MEM
//    ar_ld      out  1   load AR from bus
//    pc_inc     out  1   increment PC
//    ir_ld      out  1   load IR from bus
//    mem_rd     out  1   memory read request
//    seq_t      out  3   current state code
//    busy       out  1   registered, high outside IDLE
//    done       out  1   registered, high for the single DONE cycle
//    err        out  1   registered, sticky memory-timeout flag
//    opcode     out  3   IR[14:12] latched in T2
//    indirect   out  1   IR[15] latched in T2
// ============================================================================
module fetch_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        halt,
    input  logic        mem_ready,
    input  logic [15:0] ir_in,
    output logic [2:0]  bus_sel,
    output logic        ar_ld,
    output logic        pc_inc,
    output logic        ir_ld,
    output logic        mem_rd,
    output logic [2:0]  seq_t,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  opcode,
    output logic        indirect
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [2:0] C_BUS_NONE = 3'd0;
    localparam logic [2:0] C_BUS_AR   = 3'd1;
    localparam logic [2:0] C_BUS_PC   = 3'd2;
    localparam logic [2:0] C_BUS_IR   = 3'd3;
    localparam logic [2:0] C_BUS_MEM  = 3'd7;
    localparam logic [8:0] C_TIMEOUT  = TIMEOUT[8:0];

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [2:0] opcode_q, opcode_d;
    logic       indirect_q, indirect_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       w_launch;
    logic       w_wait_expired;
    logic       w_ir_unused;

    // Only the opcode/indirect fields are decoded here; the rest of IR
    // reaches AR over the external bus.
    assign w_ir_unused = ^ir_in[11:0];

    assign w_launch = start && !halt;

    // One more cycle without mem_ready would bring the count to TIMEOUT.
    // Evaluated 9 bits wide so TIMEOUT=255 cannot wrap.
    assign w_wait_expired = (({1'b0, wait_cnt_q} + 9'd1) >= C_TIMEOUT);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = 8'd0;
        opcode_d   = opcode_q;
        indirect_d = indirect_q;
        err_d      = err_q;
        bus_sel    = C_BUS_NONE;
        ar_ld      = 1'b0;
        pc_inc     = 1'b0;
        ir_ld      = 1'b0;
        mem_rd     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_launch) begin
                    state_d = S_T0;
                    err_d   = 1'b0;
                end
            end
            S_T0: begin
                bus_sel = C_BUS_PC;
                ar_ld   = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                if (mem_ready) begin
                    bus_sel = C_BUS_MEM;
                    mem_rd  = 1'b1;
                    ir_ld   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_T2;
                end else if (w_wait_expired) begin
                    // Abandon the fetch silently: no select, no request.
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    bus_sel    = C_BUS_AR;
                    mem_rd     = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_T2: begin
                bus_sel    = C_BUS_IR;
                ar_ld      = 1'b1;
                opcode_d   = ir_in[14:12];
                indirect_d = ir_in[15];
                state_d    = ir_in[15] ? S_T3 : S_DONE;
            end
            S_T3: begin
                if (mem_ready) begin
                    bus_sel = C_BUS_MEM;
                    mem_rd  = 1'b1;
                    ar_ld   = 1'b1;
                    state_d = S_DONE;
                end else if (w_wait_expired) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    bus_sel    = C_BUS_AR;
                    mem_rd     = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                // DONE->T0 leaves err alone; only IDLE->T0 clears it.
                state_d = w_launch ? S_T0 : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered so they line up with the state code.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 8'd0;
            opcode_q   <= 3'd0;
            indirect_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            opcode_q   <= opcode_d;
            indirect_q <= indirect_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign seq_t    = state_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign opcode   = opcode_q;
    assign indirect = indirect_q;

endmodule
`default_nettype wire
